// File: rtl/alu_sign_restore_pkg.sv
// Shared types and helpers for the divider result sign-restore pipeline.
// Operand encoding, stage-1 payload layout and the small selection helpers live here.
package alu_sign_restore_pkg;

  localparam int BITS_W = 64;
  localparam int HALF_W = 32;

  localparam logic [BITS_W-1:0] ALL_ONES = {BITS_W{1'b1}};

  typedef struct packed {
    logic is_rem;
    logic is_signed;
    logic is_word;
  } div_op_t;

  typedef struct packed {
    logic [BITS_W-1:0] mag;
    logic              neg;
    logic              is_word;
    logic              is_rem;
    logic              div_zero;
    logic [BITS_W-1:0] dividend;
  } s1_payload_t;

  // Unsigned ops never negate; otherwise pick the flag matching result kind and width.
  function automatic logic select_neg(
    input div_op_t op,
    input logic    sign_q,
    input logic    sign_r,
    input logic    sign_qw,
    input logic    sign_rw
  );
    if (!op.is_signed) begin
      return 1'b0;
    end
    if (op.is_word) begin
      return op.is_rem ? sign_rw : sign_qw;
    end
    return op.is_rem ? sign_r : sign_q;
  endfunction

  function automatic logic [BITS_W-1:0] sext_word(input logic [HALF_W-1:0] v);
    return {{(BITS_W-HALF_W){v[HALF_W-1]}}, v};
  endfunction

endpackage

// File: rtl/alu_sign_restore_sign_fix.sv
// Combinational sign restore: two's-complement negate of a magnitude, with the
// word form negating only the low half and sign-extending from bit 31.
module sign_fix_unit
  import alu_sign_restore_pkg::*;
(
  input  logic [BITS_W-1:0] mag,
  input  logic              neg,
  input  logic              is_word,
  output logic [BITS_W-1:0] result
);

  logic [BITS_W-1:0] full_neg;
  logic [HALF_W-1:0] r32;
  logic [BITS_W-1:0] word_ext;

  // MIN magnitude negates to itself, which is exactly the overflow result.
  assign full_neg = ~mag + {{(BITS_W-1){1'b0}}, 1'b1};
  assign r32      = neg ? (~mag[HALF_W-1:0] + {{(HALF_W-1){1'b0}}, 1'b1})
                        : mag[HALF_W-1:0];

  assign word_ext[HALF_W-1:0] = r32;

  genvar gi;
  generate
    for (gi = HALF_W; gi < BITS_W; gi = gi + 1) begin : g_sext
      assign word_ext[gi] = r32[HALF_W-1];
    end
  endgenerate

  assign result = is_word ? word_ext : (neg ? full_neg : mag);

endmodule

// File: rtl/alu_sign_restore.sv
// Two-stage valid/ready pipeline restoring signed DIV/REM results (incl. W forms)
// from unsigned divider magnitudes, with the divide-by-zero override in stage 2.
module alu_sign_restore
  import alu_sign_restore_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  div_op_t           in_op,
  input  logic [BITS_W-1:0] in_quot,
  input  logic [BITS_W-1:0] in_rem,
  input  logic              in_sign_q,
  input  logic              in_sign_r,
  input  logic              in_sign_qw,
  input  logic              in_sign_rw,
  input  logic              in_div_zero,
  input  logic [BITS_W-1:0] in_dividend,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BITS_W-1:0] out_result
);

  s1_payload_t       s1_payload_reg;
  s1_payload_t       s1_payload_next;
  logic              s1_valid_reg;
  logic              s2_valid_reg;
  logic [BITS_W-1:0] s2_result_reg;
  logic [BITS_W-1:0] s2_result_next;
  logic [BITS_W-1:0] fix_result;
  logic              s1_adv;
  logic              s2_adv;

  // Ready is derived only from downstream occupancy, never from in_valid.
  assign s2_adv   = !s2_valid_reg || out_ready;
  assign s1_adv   = !s1_valid_reg || s2_adv;
  assign in_ready = s1_adv;

  always_comb begin
    s1_payload_next          = '0;
    s1_payload_next.mag      = in_op.is_rem ? in_rem : in_quot;
    s1_payload_next.neg      = select_neg(in_op, in_sign_q, in_sign_r, in_sign_qw, in_sign_rw);
    s1_payload_next.is_word  = in_op.is_word;
    s1_payload_next.is_rem   = in_op.is_rem;
    s1_payload_next.div_zero = in_div_zero;
    s1_payload_next.dividend = in_dividend;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_reg   <= 1'b0;
      s1_payload_reg <= '0;
    end else if (s1_adv) begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        s1_payload_reg <= s1_payload_next;
      end
    end
  end

  sign_fix_unit u_sign_fix (
    .mag     (s1_payload_reg.mag),
    .neg     (s1_payload_reg.neg),
    .is_word (s1_payload_reg.is_word),
    .result  (fix_result)
  );

  // Divide-by-zero wins over any sign flag, signed or not.
  always_comb begin
    s2_result_next = fix_result;
    if (s1_payload_reg.div_zero) begin
      if (!s1_payload_reg.is_rem) begin
        s2_result_next = ALL_ONES;
      end else if (s1_payload_reg.is_word) begin
        s2_result_next = sext_word(s1_payload_reg.dividend[HALF_W-1:0]);
      end else begin
        s2_result_next = s1_payload_reg.dividend;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid_reg  <= 1'b0;
      s2_result_reg <= '0;
    end else if (s2_adv) begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        s2_result_reg <= s2_result_next;
      end
    end
  end

  assign out_valid  = s2_valid_reg;
  assign out_result = s2_result_reg;

endmodule
